trap_ctrl: RTL and testbench

//  Supervisor trap sequencer for the pipelined core; sits beside the EX stage.

---
 rtl/trap_ctrl_if.sv | 38 +++
 rtl/trap_ctrl.sv | 128 ++++++++++++
 tb/tb_trap_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// EX-stage trap interface: decoded EX instruction and external IRQ in, pipeline
// control and CSR read data out. The core side is master, trap_ctrl is slave.
interface trap_ctrl_if;
  // ex_valid qualifies every ex_* field in the same cycle. There is no ready;
  // the sequencer acts on a request only in IDLE and signals back through
  // flush_front/kill_ex/pc_stall/redirect, with busy high while it sequences.
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_int;
  logic [7:0]  ex_scause;
  logic        ex_mret;
  logic        ex_csrrs;
  logic [11:0] ex_csr_addr;
  logic [31:0] ex_csr_wdata;
  logic        ext_irq;
  logic [31:0] csr_rdata;
  logic        flush_front;
  logic        kill_ex;
  logic        pc_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;
  logic [1:0]  dbg_state;

  modport master (
    output ex_valid, ex_pc, ex_int, ex_scause, ex_mret, ex_csrrs,
           ex_csr_addr, ex_csr_wdata, ext_irq,
    input  csr_rdata, flush_front, kill_ex, pc_stall, redirect, redirect_pc,
           busy, dbg_state
  );

  modport slave (
    input  ex_valid, ex_pc, ex_int, ex_scause, ex_mret, ex_csrrs,
           ex_csr_addr, ex_csr_wdata, ext_irq,
    output csr_rdata, flush_front, kill_ex, pc_stall, redirect, redirect_pc,
           busy, dbg_state
  );
endinterface

// File: rtl/trap_ctrl.sv
// Supervisor trap sequencer beside EX: owns sstatus/stvec/sepc/scause and runs
// the two-cycle flush-then-redirect sequence for trap entry and MRET.
module trap_ctrl #(
  parameter logic [31:0] RESET_STVEC = 32'h0000_0100,
  parameter logic [30:0] IRQ_CODE    = 31'd9
) (
  input  logic        clk,
  input  logic        rstn,
  trap_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENTER  = 2'd1,
    S_RETURN = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        sie, spie;
  logic [31:0] stvec, sepc, scause;
  logic [31:0] sstatus;
  logic        irq_req;
  logic        take_exc, take_irq, csr_we;

  assign sstatus       = {26'b0, spie, 3'b0, sie, 1'b0};
  assign irq_req       = bus.ext_irq & sie;
  assign bus.busy      = (state != S_IDLE);
  assign bus.dbg_state = state;

  always_comb begin
    case (bus.ex_csr_addr)
      12'h100: bus.csr_rdata = sstatus;
      12'h105: bus.csr_rdata = stvec;
      12'h141: bus.csr_rdata = sepc;
      12'h142: bus.csr_rdata = scause;
      default: bus.csr_rdata = 32'b0;
    endcase
  end

  // Control outputs are forced low while rstn is low so an aborted sequence
  // never issues its redirect.
  always_comb begin
    state_nxt       = state;
    take_exc        = 1'b0;
    take_irq        = 1'b0;
    csr_we          = 1'b0;
    bus.flush_front = 1'b0;
    bus.kill_ex     = 1'b0;
    bus.pc_stall    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'b0;
    if (rstn) begin
      case (state)
        S_IDLE: begin
          if (bus.ex_valid) begin
            if (bus.ex_int) begin
              take_exc        = 1'b1;
              bus.flush_front = 1'b1;
              bus.pc_stall    = 1'b1;
              state_nxt       = S_ENTER;
            end else if (irq_req) begin
              take_irq        = 1'b1;
              bus.flush_front = 1'b1;
              bus.pc_stall    = 1'b1;
              bus.kill_ex     = 1'b1;
              state_nxt       = S_ENTER;
            end else if (bus.ex_mret) begin
              bus.flush_front = 1'b1;
              bus.pc_stall    = 1'b1;
              state_nxt       = S_RETURN;
            end else if (bus.ex_csrrs) begin
              csr_we = 1'b1;
            end
          end
        end
        S_ENTER: begin
          bus.redirect    = 1'b1;
          bus.redirect_pc = {stvec[31:2], 2'b00};
          bus.flush_front = 1'b1;
          bus.kill_ex     = 1'b1;
          state_nxt       = S_IDLE;
        end
        S_RETURN: begin
          bus.redirect    = 1'b1;
          bus.redirect_pc = sepc;
          bus.flush_front = 1'b1;
          bus.kill_ex     = 1'b1;
          state_nxt       = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= S_IDLE;
      sie    <= 1'b0;
      spie   <= 1'b0;
      stvec  <= RESET_STVEC;
      sepc   <= 32'b0;
      scause <= 32'b0;
    end else begin
      state <= state_nxt;
      if (take_exc || take_irq) begin
        sepc   <= bus.ex_pc;
        scause <= take_exc ? {24'b0, bus.ex_scause} : {1'b1, IRQ_CODE};
        spie   <= sie;
        sie    <= 1'b0;
      end else if (state == S_RETURN) begin
        sie  <= spie;
        spie <= 1'b1;
      end else if (csr_we) begin
        case (bus.ex_csr_addr)
          12'h100: begin
            sie  <= sie  | bus.ex_csr_wdata[1];
            spie <= spie | bus.ex_csr_wdata[5];
          end
          12'h105: stvec  <= (stvec | bus.ex_csr_wdata) & 32'hFFFF_FFFC;
          12'h141: sepc   <= (sepc  | bus.ex_csr_wdata) & 32'hFFFF_FFFC;
          12'h142: scause <= scause | bus.ex_csr_wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: exception/IRQ entry, MRET, CSRRS, priority,
// masking and reset abort, each scenario in its own task.
module tb_trap_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_run  = 0;
  int   n_fail = 0;

  trap_ctrl_if bus ();

  trap_ctrl #(
    .RESET_STVEC(32'h0000_0100),
    .IRQ_CODE   (31'd9)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ex_valid     = 1'b0;
    bus.ex_pc        = 32'b0;
    bus.ex_int       = 1'b0;
    bus.ex_scause    = 8'b0;
    bus.ex_mret      = 1'b0;
    bus.ex_csrrs     = 1'b0;
    bus.ex_csr_addr  = 12'b0;
    bus.ex_csr_wdata = 32'b0;
    bus.ext_irq      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    #1;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    bus.ex_csr_addr = a;
    #1;
    d = bus.csr_rdata;
  endtask

  task automatic csrrs(input logic [11:0] a, input logic [31:0] w);
    idle_inputs();
    bus.ex_valid = 1'b1; bus.ex_csrrs = 1'b1;
    bus.ex_csr_addr = a; bus.ex_csr_wdata = w;
    tick();
    idle_inputs();
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    n_run++; if (bus.flush_front !== 1'b0) begin n_fail++; $display("FAIL rst_flush got=%0h exp=0", bus.flush_front); end
    n_run++; if (bus.kill_ex !== 1'b0) begin n_fail++; $display("FAIL rst_kill got=%0h exp=0", bus.kill_ex); end
    n_run++; if (bus.pc_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%0h exp=0", bus.pc_stall); end
    n_run++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL rst_redirect got=%0h exp=0", bus.redirect); end
    n_run++; if (bus.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rst_rpc got=%0h exp=0", bus.redirect_pc); end
    n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0h exp=0", bus.busy); end
    n_run++; if (bus.dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state got=%0h exp=0", bus.dbg_state); end
    rd(12'h100, d); n_run++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_sstatus got=%0h exp=0", d); end
    rd(12'h105, d); n_run++; if (d !== 32'h100) begin n_fail++; $display("FAIL rst_stvec got=%0h exp=100", d); end
    rd(12'h141, d); n_run++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_sepc got=%0h exp=0", d); end
    rd(12'h142, d); n_run++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_scause got=%0h exp=0", d); end
  endtask

  task automatic test_ecall();
    logic [31:0] d;
    idle_inputs();
    bus.ex_valid = 1'b1; bus.ex_int = 1'b1; bus.ex_pc = 32'h40; bus.ex_scause = 8'h8;
    #1;
    n_run++; if (bus.flush_front !== 1'b1) begin n_fail++; $display("FAIL ecall_flush got=%0h exp=1", bus.flush_front); end
    n_run++; if (bus.pc_stall !== 1'b1) begin n_fail++; $display("FAIL ecall_stall got=%0h exp=1", bus.pc_stall); end
    n_run++; if (bus.kill_ex !== 1'b0) begin n_fail++; $display("FAIL ecall_kill got=%0h exp=0", bus.kill_ex); end
    n_run++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL ecall_redir_t got=%0h exp=0", bus.redirect); end
    tick();
    #1;
    n_run++; if (bus.redirect !== 1'b1) begin n_fail++; $display("FAIL ecall_redir got=%0h exp=1", bus.redirect); end
    n_run++; if (bus.redirect_pc !== 32'h100) begin n_fail++; $display("FAIL ecall_rpc got=%0h exp=100", bus.redirect_pc); end
    n_run++; if (bus.kill_ex !== 1'b1) begin n_fail++; $display("FAIL ecall_kill_enter got=%0h exp=1", bus.kill_ex); end
    n_run++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL ecall_busy got=%0h exp=1", bus.busy); end
    idle_inputs();
    tick();
    n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ecall_idle got=%0h exp=0", bus.busy); end
    rd(12'h141, d); n_run++; if (d !== 32'h40) begin n_fail++; $display("FAIL ecall_sepc got=%0h exp=40", d); end
    rd(12'h142, d); n_run++; if (d !== 32'h8) begin n_fail++; $display("FAIL ecall_scause got=%0h exp=8", d); end
    rd(12'h100, d); n_run++; if (d !== 32'h0) begin n_fail++; $display("FAIL ecall_sstatus got=%0h exp=0", d); end
  endtask

  task automatic test_csrrs();
    logic [31:0] d;
    idle_inputs();
    bus.ex_valid = 1'b1; bus.ex_csrrs = 1'b1; bus.ex_csr_addr = 12'h105; bus.ex_csr_wdata = 32'h203;
    #1;
    n_run++; if (bus.csr_rdata !== 32'h100) begin n_fail++; $display("FAIL csrrs_old got=%0h exp=100", bus.csr_rdata); end
    n_run++; if (bus.flush_front !== 1'b0) begin n_fail++; $display("FAIL csrrs_flush got=%0h exp=0", bus.flush_front); end
    tick();
    idle_inputs();
    rd(12'h105, d); n_run++; if (d !== 32'h300) begin n_fail++; $display("FAIL csrrs_stvec got=%0h exp=300", d); end
    csrrs(12'h100, 32'h2);
    rd(12'h100, d); n_run++; if (d !== 32'h2) begin n_fail++; $display("FAIL csrrs_sie got=%0h exp=2", d); end
    csrrs(12'h141, 32'h47);
    rd(12'h141, d); n_run++; if (d !== 32'h44) begin n_fail++; $display("FAIL csrrs_sepc got=%0h exp=44", d); end
    csrrs(12'h7C0, 32'hFF);
    rd(12'h7C0, d); n_run++; if (d !== 32'h0) begin n_fail++; $display("FAIL csrrs_unmapped got=%0h exp=0", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    idle_inputs();
    bus.ex_valid = 1'b1; bus.ex_pc = 32'h80; bus.ext_irq = 1'b1;
    #1;
    n_run++; if (bus.kill_ex !== 1'b1) begin n_fail++; $display("FAIL irq_kill got=%0h exp=1", bus.kill_ex); end
    n_run++; if (bus.flush_front !== 1'b1) begin n_fail++; $display("FAIL irq_flush got=%0h exp=1", bus.flush_front); end
    n_run++; if (bus.pc_stall !== 1'b1) begin n_fail++; $display("FAIL irq_stall got=%0h exp=1", bus.pc_stall); end
    tick();
    idle_inputs();
    #1;
    n_run++; if (bus.redirect !== 1'b1) begin n_fail++; $display("FAIL irq_redir got=%0h exp=1", bus.redirect); end
    n_run++; if (bus.redirect_pc !== 32'h300) begin n_fail++; $display("FAIL irq_rpc got=%0h exp=300", bus.redirect_pc); end
    tick();
    rd(12'h141, d); n_run++; if (d !== 32'h80) begin n_fail++; $display("FAIL irq_sepc got=%0h exp=80", d); end
    rd(12'h142, d); n_run++; if (d !== 32'h8000_0009) begin n_fail++; $display("FAIL irq_scause got=%0h exp=80000009", d); end
    rd(12'h100, d); n_run++; if (d !== 32'h20) begin n_fail++; $display("FAIL irq_sstatus got=%0h exp=20", d); end
  endtask

  task automatic test_mret();
    logic [31:0] d;
    do_reset();
    csrrs(12'h141, 32'h44);
    csrrs(12'h100, 32'h20);
    bus.ex_valid = 1'b1; bus.ex_mret = 1'b1; bus.ex_pc = 32'h90;
    #1;
    n_run++; if (bus.flush_front !== 1'b1) begin n_fail++; $display("FAIL mret_flush got=%0h exp=1", bus.flush_front); end
    n_run++; if (bus.pc_stall !== 1'b1) begin n_fail++; $display("FAIL mret_stall got=%0h exp=1", bus.pc_stall); end
    n_run++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL mret_redir_t got=%0h exp=0", bus.redirect); end
    tick();
    idle_inputs();
    #1;
    n_run++; if (bus.redirect !== 1'b1) begin n_fail++; $display("FAIL mret_redir got=%0h exp=1", bus.redirect); end
    n_run++; if (bus.redirect_pc !== 32'h44) begin n_fail++; $display("FAIL mret_rpc got=%0h exp=44", bus.redirect_pc); end
    n_run++; if (bus.kill_ex !== 1'b1) begin n_fail++; $display("FAIL mret_kill got=%0h exp=1", bus.kill_ex); end
    tick();
    n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mret_busy got=%0h exp=0", bus.busy); end
    rd(12'h100, d); n_run++; if (d !== 32'h22) begin n_fail++; $display("FAIL mret_sstatus got=%0h exp=22", d); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    idle_inputs();
    bus.ex_valid = 1'b1; bus.ex_int = 1'b1; bus.ex_pc = 32'h60; bus.ex_scause = 8'h8;
    bus.ext_irq = 1'b1; bus.ex_csrrs = 1'b1; bus.ex_csr_addr = 12'h105; bus.ex_csr_wdata = 32'h1000;
    #1;
    n_run++; if (bus.kill_ex !== 1'b0) begin n_fail++; $display("FAIL prio_kill got=%0h exp=0", bus.kill_ex); end
    tick();
    bus.ex_int = 1'b0; bus.ex_csrrs = 1'b0; bus.ex_pc = 32'h64;
    #1;
    n_run++; if (bus.redirect_pc !== 32'h100) begin n_fail++; $display("FAIL prio_rpc got=%0h exp=100", bus.redirect_pc); end
    tick();
    n_run++; if (bus.flush_front !== 1'b0) begin n_fail++; $display("FAIL prio_masked got=%0h exp=0", bus.flush_front); end
    rd(12'h142, d); n_run++; if (d !== 32'h8) begin n_fail++; $display("FAIL prio_scause got=%0h exp=8", d); end
    rd(12'h105, d); n_run++; if (d !== 32'h100) begin n_fail++; $display("FAIL prio_stvec got=%0h exp=100", d); end
    rd(12'h100, d); n_run++; if (d !== 32'h20) begin n_fail++; $display("FAIL prio_sstatus got=%0h exp=20", d); end
    bus.ex_csrrs = 1'b1; bus.ex_csr_addr = 12'h100; bus.ex_csr_wdata = 32'h2;
    tick();
    bus.ex_csrrs = 1'b0;
    #1;
    n_run++; if (bus.kill_ex !== 1'b1) begin n_fail++; $display("FAIL prio_pend_kill got=%0h exp=1", bus.kill_ex); end
    tick();
    idle_inputs();
    #1;
    n_run++; if (bus.redirect !== 1'b1) begin n_fail++; $display("FAIL prio_pend_redir got=%0h exp=1", bus.redirect); end
    tick();
    rd(12'h142, d); n_run++; if (d !== 32'h8000_0009) begin n_fail++; $display("FAIL prio_pend_scause got=%0h exp=80000009", d); end
    rd(12'h141, d); n_run++; if (d !== 32'h64) begin n_fail++; $display("FAIL prio_pend_sepc got=%0h exp=64", d); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d;
    idle_inputs();
    bus.ex_valid = 1'b1; bus.ex_int = 1'b1; bus.ex_pc = 32'h70; bus.ex_scause = 8'h2;
    tick();
    idle_inputs();
    #1;
    n_run++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_enter got=%0h exp=1", bus.busy); end
    rstn = 1'b0;
    #1;
    n_run++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL abort_redir_rst got=%0h exp=0", bus.redirect); end
    tick();
    rstn = 1'b1;
    #1;
    n_run++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL abort_redir got=%0h exp=0", bus.redirect); end
    n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%0h exp=0", bus.busy); end
    rd(12'h105, d); n_run++; if (d !== 32'h100) begin n_fail++; $display("FAIL abort_stvec got=%0h exp=100", d); end
    rd(12'h141, d); n_run++; if (d !== 32'h0) begin n_fail++; $display("FAIL abort_sepc got=%0h exp=0", d); end
    rd(12'h142, d); n_run++; if (d !== 32'h0) begin n_fail++; $display("FAIL abort_scause got=%0h exp=0", d); end
  endtask

  task automatic test_no_valid();
    csrrs(12'h100, 32'h2);
    bus.ext_irq = 1'b1;
    #1;
    n_run++; if (bus.flush_front !== 1'b0) begin n_fail++; $display("FAIL novalid_flush got=%0h exp=0", bus.flush_front); end
    tick();
    n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL novalid_busy got=%0h exp=0", bus.busy); end
    do_reset();
    bus.ex_valid = 1'b1; bus.ex_pc = 32'hA0; bus.ext_irq = 1'b1;
    #1;
    n_run++; if (bus.flush_front !== 1'b0) begin n_fail++; $display("FAIL masked_flush got=%0h exp=0", bus.flush_front); end
    n_run++; if (bus.kill_ex !== 1'b0) begin n_fail++; $display("FAIL masked_kill got=%0h exp=0", bus.kill_ex); end
    tick();
    n_run++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL masked_redir got=%0h exp=0", bus.redirect); end
    n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL masked_busy got=%0h exp=0", bus.busy); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_ecall();
    test_csrrs();
    test_irq();
    test_mret();
    test_priority();
    test_reset_abort();
    test_no_valid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
